// File: rtl/psd_pkg.sv
// Shared types and defaults for the PSD frame controller.
// Holds the control FSM state type and default sizing.
package psd_pkg;

    localparam int PSD_W       = 16;
    localparam int PSD_N       = 256;
    localparam int PSD_MAX_AVG = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        DONE
    } psd_ctrl_state_t;

endpackage

// File: rtl/psd_frame_ctrl_if.sv
// Sample streams between source, frame controller and datapath.
// slave = controller side, master = source/sink side.
interface psd_frame_ctrl_if
    import psd_pkg::*;
#(
    parameter int W = PSD_W,
    parameter int N = PSD_N
);

    logic [W-1:0]         s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [W-1:0]         m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [$clog2(N)-1:0] win_addr;
    logic                 m_last;
    logic                 m_avg_last;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid,
        input  win_addr, m_last, m_avg_last
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid,
        output win_addr, m_last, m_avg_last
    );

endinterface

// File: rtl/psd_out_reg.sv
// Output register stage: holds one sample plus its window index
// and frame flags until the downstream datapath accepts it.
module psd_out_reg #(
    parameter int W = 16,
    parameter int N = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [W-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_addr,
    input  logic                 in_last,
    input  logic                 in_avg_last,
    input  logic                 m_ready,
    output logic [W-1:0]         m_data,
    output logic [$clog2(N)-1:0] win_addr,
    output logic                 m_valid,
    output logic                 m_last,
    output logic                 m_avg_last,
    output logic                 can_load
);

    assign can_load = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_data     <= '0;
            win_addr   <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_avg_last <= 1'b0;
        end else if (clr) begin
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_avg_last <= 1'b0;
        end else if (load) begin
            m_data     <= in_data;
            win_addr   <= in_addr;
            m_valid    <= 1'b1;
            m_last     <= in_last;
            m_avg_last <= in_avg_last;
        end else if (m_ready) begin
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_avg_last <= 1'b0;
        end
    end

endmodule

// File: rtl/psd_frame_ctrl.sv
// Frame sequencer for PSD averaging: slices the input stream into
// N-sample frames and waits for the datapath between frames.
module psd_frame_ctrl
    import psd_pkg::*;
#(
    parameter int W       = PSD_W,
    parameter int N       = PSD_N,
    parameter int MAX_AVG = PSD_MAX_AVG
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(MAX_AVG):0]   num_avg,
    psd_frame_ctrl_if.slave            bus,
    input  logic                       dp_frame_done,
    output logic                       busy,
    output logic                       done
);

    localparam int SW = $clog2(N);
    localparam int AW = $clog2(MAX_AVG) + 1;

    psd_ctrl_state_t state, state_n;

    logic [SW-1:0] scnt;
    logic [AW-1:0] fcnt;
    logic [AW-1:0] avg_n;
    logic [AW-1:0] avg_in;
    logic          pend;
    logic          can_load;
    logic          s_rdy;
    logic          xfer;
    logic          scnt_end;
    logic          f_end;
    logic          mv;
    logic          ml;
    logic          fd_hit;

    assign s_rdy       = (state == RUN) && can_load;
    assign bus.s_ready = s_rdy;
    assign bus.m_valid = mv;
    assign bus.m_last  = ml;
    assign xfer        = bus.s_valid && s_rdy;
    assign scnt_end    = (scnt == SW'(N - 1));
    assign f_end       = (fcnt == avg_n - 1'b1);
    assign busy        = (state == RUN) || (state == WAIT);
    assign done        = (state == DONE);

    // A frame completion only counts once its m_last has left the register.
    assign fd_hit = (state == WAIT) && (dp_frame_done || pend)
                    && !(mv && ml);

    always_comb begin
        avg_in = num_avg;
        if (num_avg == '0)
            avg_in = AW'(1);
        else if (num_avg > AW'(MAX_AVG))
            avg_in = AW'(MAX_AVG);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (xfer && scnt_end) state_n = WAIT;
            WAIT:    if (fd_hit) state_n = f_end ? DONE : RUN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || abort) begin
            scnt  <= '0;
            fcnt  <= '0;
            avg_n <= '0;
            pend  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                avg_n <= avg_in;
                scnt  <= '0;
                fcnt  <= '0;
                pend  <= 1'b0;
            end
            if (xfer)
                scnt <= scnt + 1'b1;
            if (fd_hit) begin
                pend <= 1'b0;
                if (!f_end)
                    fcnt <= fcnt + 1'b1;
            end else if (state == WAIT && dp_frame_done) begin
                pend <= 1'b1;
            end
        end
    end

    psd_out_reg #(
        .W (W),
        .N (N)
    ) u_out (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (abort),
        .load        (xfer),
        .in_data     (bus.s_data),
        .in_addr     (scnt),
        .in_last     (scnt_end),
        .in_avg_last (scnt_end && f_end),
        .m_ready     (bus.m_ready),
        .m_data      (bus.m_data),
        .win_addr    (bus.win_addr),
        .m_valid     (mv),
        .m_last      (ml),
        .m_avg_last  (bus.m_avg_last),
        .can_load    (can_load)
    );

endmodule

// File: doc/psd_frame_ctrl.md
PSD_FRAME_CTRL -- requirements
Module: psd_frame_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter N, default 256, meaning samples per frame (power of 2, >= 4).
REQ-003 SHALL have parameter MAX_AVG, default 64, meaning maximum frames averaged per run.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate the run; return to IDLE.
REQ-008 SHALL have port num_avg  input  $clog2(MAX_AVG)+1  frames per run; sampled on accepted start.
REQ-009 SHALL have port s_data / s_valid / s_ready  in/in/out  W/1/1  input sample stream.
REQ-010 SHALL have port m_data / m_valid / m_ready  out/out/in  W/1/1  sample stream to the windowing/FFT datapath.
REQ-011 SHALL have port win_addr  output  $clog2(N)  window-ROM index aligned with m_data.
REQ-012 SHALL have port m_last  output  1  marks the last sample of a frame, qualified by m_valid.
REQ-013 SHALL have port m_avg_last  output  1  marks m_last of the final frame of a run.
REQ-014 SHALL have port dp_frame_done  input  1  one-cycle pulse from datapath: frame processed.
REQ-015 SHALL have ports busy / done  output / output  1 / 1  run active; one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, WAIT, DONE.
REQ-017 IDLE -> RUN on start; latch num_avg, with 0 treated as 1 and values > MAX_AVG clamped to MAX_AVG; clear sample and frame counters.
REQ-018 In RUN: s_ready = (!m_valid || m_ready); a transfer loads m_data and win_addr = sample index into the output register (latency 1 cycle); m_valid holds until m_ready.
REQ-019 The sample counter SHALL increment per input transfer and wrap from N-1 to 0; the output carrying index N-1 SHALL assert m_last.
REQ-020 On the input transfer of index N-1: RUN -> WAIT; s_ready SHALL be 0 in WAIT, DONE and IDLE.
REQ-021 In WAIT, on dp_frame_done: if frame count = latched num_avg-1 -> DONE, else increment frame count and -> RUN.
REQ-022 dp_frame_done arriving before m_last has been accepted SHALL be latched and applied once WAIT is reached; dp_frame_done in IDLE or RUN with no frame pending SHALL be ignored.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE; busy = 1 in RUN and WAIT only.
REQ-024 abort has priority over all transitions: next state IDLE, m_valid cleared, counters cleared, no done pulse.
REQ-025 start while not IDLE, and start coincident with abort, SHALL be ignored.
REQ-026 m_avg_last = m_last AND (frame count = num_avg-1).

Reset
REQ-027 On reset_n=0 at a clock edge: state IDLE; m_valid, m_last, m_avg_last, done, busy = 0; m_data, win_addr, counters = 0; pending-done flag cleared.
REQ-028 Reset asserted mid-run SHALL discard the run identically to abort.

Structure
REQ-029 Package psd_pkg SHALL hold the state enum psd_ctrl_state_t and the defaults PSD_W, PSD_N, PSD_MAX_AVG.
REQ-030 The output register (data, win_addr, last flags, valid/ready) SHALL be the sub-module psd_out_reg; FSM and counters stay in psd_frame_ctrl.

Verification
REQ-031 N=8, num_avg=2, s_valid and m_ready held 1, dp_frame_done issued 3 cycles after each m_last -> 16 outputs, win_addr 0..7 twice, m_last twice, m_avg_last once on the second, single done pulse.
REQ-032 num_avg=0 -> exactly one frame, m_avg_last set on its m_last.
REQ-033 m_ready toggling 1,0 each cycle, N=8 -> no sample lost or duplicated; m_data stable while m_valid=1 and m_ready=0.
REQ-034 abort asserted at sample 5 of frame 1 -> next cycle busy=0, m_valid=0, no done; a following start produces win_addr from 0.
REQ-035 dp_frame_done pulsed while m_last is stalled by m_ready=0 -> after m_last is accepted the FSM goes directly to RUN/DONE with no further pulse needed.
REQ-036 start pulsed during RUN and reset_n=0 during WAIT -> start ignored; reset returns all outputs to REQ-027 values.
